// File: rtl/spec_host_wb_bridge_pkg.sv
// Shared constants, state type and window decoder for the SPEC host-to-Wishbone bridge.
package spec_bridge_pkg;

    localparam logic [31:0] C_WRPC_BASE   = 32'h0008_0000;
    localparam logic [31:0] C_PERIPH_BASE = 32'h000A_0000;
    localparam int          C_WIN_BITS    = 17;

    localparam logic        SLV_WRPC   = 1'b0;
    localparam logic        SLV_PERIPH = 1'b1;

    // Returned to the host for reads that fail (unmapped or timed out).
    localparam logic [31:0] C_ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } t_bridge_state;

    typedef struct packed {
        logic valid;
        logic sel;
    } t_decode;

    // A window matches when every address bit above the window size equals the base.
    function automatic t_decode decode_addr(input logic [31:0] addr,
                                            input logic [31:0] wrpc_base,
                                            input logic [31:0] periph_base,
                                            input int          win_bits);
        t_decode d;
        d.valid = 1'b0;
        d.sel   = SLV_WRPC;
        if ((addr >> win_bits) == (wrpc_base >> win_bits)) begin
            d.valid = 1'b1;
            d.sel   = SLV_WRPC;
        end else if ((addr >> win_bits) == (periph_base >> win_bits)) begin
            d.valid = 1'b1;
            d.sel   = SLV_PERIPH;
        end
        return d;
    endfunction

endpackage

// File: rtl/spec_host_wb_bridge_if.sv
// Host request/response and Wishbone signals of the bridge; slave = bridge side, master = environment side.
interface spec_host_wb_bridge_if;
    logic        host_req_i;
    logic        host_we_i;
    logic [31:0] host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_ready_o;
    logic        host_rsp_valid_o;
    logic [31:0] host_rsp_data_o;
    logic        host_rsp_err_o;
    logic [1:0]  wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [63:0] wb_dat_i;
    logic [1:0]  wb_ack_i;

    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, wb_dat_i, wb_ack_i,
        output host_ready_o, host_rsp_valid_o, host_rsp_data_o, host_rsp_err_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

    modport master (
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, wb_dat_i, wb_ack_i,
        input  host_ready_o, host_rsp_valid_o, host_rsp_data_o, host_rsp_err_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );
endinterface

// File: rtl/spec_host_wb_bridge_timeout.sv
// Loadable down-counter guarding a Wishbone access; expired once it has counted down to zero.
module spec_bridge_timeout #(
    parameter int CNT_W = 10
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over load, load wins over counting; the count parks at zero.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i)                  r_cnt <= '0;
        else if (i_clr)                r_cnt <= '0;
        else if (i_load)               r_cnt <= i_load_val;
        else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/spec_host_wb_bridge.sv
// Single-outstanding host-to-Wishbone bridge with two decoded windows and bus timeout.
module spec_host_wb_bridge
    import spec_bridge_pkg::*;
#(
    parameter logic [31:0] WRPC_BASE      = C_WRPC_BASE,
    parameter logic [31:0] PERIPH_BASE    = C_PERIPH_BASE,
    parameter int          WIN_BITS       = C_WIN_BITS,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_n_i,
    spec_host_wb_bridge_if.slave bus
);
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loaded at accept so that the last BUS cycle is the TIMEOUT_CYCLES-th one.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    t_bridge_state r_state, w_state_nxt;
    logic          r_we, r_hit, r_sel;
    logic [31:0]   r_adr, r_wdata, r_rsp_data;
    logic          r_rsp_err;

    t_decode       w_dec;
    logic          w_accept, w_ack, w_bus_act, w_to_exp, w_to_en;
    logic          w_rsp_load, w_rsp_err;
    logic [31:0]   w_rsp_data, w_lane;

    assign w_accept  = bus.host_req_i && (r_state == ST_IDLE);
    assign w_dec     = decode_addr(bus.host_addr_i, WRPC_BASE, PERIPH_BASE, WIN_BITS);
    assign w_ack     = bus.wb_ack_i[r_sel];
    assign w_lane    = (r_sel == SLV_PERIPH) ? bus.wb_dat_i[63:32] : bus.wb_dat_i[31:0];
    // Unmapped requests also pass through BUS but never raise cyc/stb, which keeps every
    // response at a minimum of two cycles after accept.
    assign w_bus_act = (r_state == ST_BUS) && r_hit;

    spec_bridge_timeout #(.CNT_W(TO_W)) u_timeout (
        .clk_sys_i  (clk_sys_i),
        .rst_n_i    (rst_n_i),
        .i_clr      (w_rsp_load),
        .i_load     (w_accept),
        .i_load_val (TO_LOAD),
        .i_en       (w_to_en),
        .o_expired  (w_to_exp)
    );

    // State register plus request capture at accept and response capture on leaving BUS.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_hit      <= 1'b0;
            r_sel      <= SLV_WRPC;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= bus.host_we_i;
                r_hit   <= w_dec.valid;
                r_sel   <= w_dec.sel;
                r_adr   <= {{(32-WIN_BITS){1'b0}}, bus.host_addr_i[WIN_BITS-1:2], 2'b00};
                r_wdata <= bus.host_wdata_i;
            end
            if (w_rsp_load) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
        end
    end

    // Next state and response selection: unmapped, acked, or timed out.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_load  = 1'b0;
        w_rsp_data  = '0;
        w_rsp_err   = 1'b0;
        w_to_en     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_BUS;
            ST_BUS: begin
                if (!r_hit) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_data  = r_we ? 32'h0 : C_ERR_RDATA;
                end else if (w_ack) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_data  = r_we ? 32'h0 : w_lane;
                end else if (w_to_exp) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_data  = r_we ? 32'h0 : C_ERR_RDATA;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus controls decode straight from state so reset drops cyc/stb without waiting for a clock.
    assign bus.host_ready_o     = (r_state == ST_IDLE);
    assign bus.host_rsp_valid_o = (r_state == ST_RESP);
    assign bus.host_rsp_data_o  = r_rsp_data;
    assign bus.host_rsp_err_o   = r_rsp_err;
    assign bus.wb_cyc_o         = w_bus_act ? ((r_sel == SLV_PERIPH) ? 2'b10 : 2'b01) : 2'b00;
    assign bus.wb_stb_o         = w_bus_act;
    assign bus.wb_we_o          = w_bus_act && r_we;
    assign bus.wb_sel_o         = w_bus_act ? 4'hF : 4'h0;
    assign bus.wb_adr_o         = r_adr;
    assign bus.wb_dat_o         = r_wdata;
endmodule

// File: tb/tb_spec_host_wb_bridge.sv
// Scoreboard bench for spec_host_wb_bridge with a two-slave RAM model and controllable ack behaviour.
module tb_spec_host_wb_bridge;
    import spec_bridge_pkg::*;

    localparam int TO    = 1024;
    localparam int BOUND = 3000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  cyc;
        logic [31:0] adr;
        logic [31:0] rdata;
        logic        err;
    } row_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk_sys_i = 1'b0;
    logic rst_n_i   = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    spec_host_wb_bridge_if bus ();

    spec_host_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_sys_i (clk_sys_i),
        .rst_n_i   (rst_n_i),
        .bus       (bus.slave)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    // Slave model: two word RAMs, programmable wait states, ack enable and a spurious ack on slave 1.
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [1:0]  ack_en  = 2'b11;
    logic        spur1   = 1'b0;
    int          wait_st = 0;
    int          wcnt    = 0;
    logic [9:0]  w_idx;
    logic        w_ack0, w_ack1;

    assign w_idx  = bus.wb_adr_o[11:2];
    assign w_ack0 = bus.wb_cyc_o[0] & bus.wb_stb_o & ack_en[0] & (wcnt >= wait_st);
    assign w_ack1 = (bus.wb_cyc_o[1] & bus.wb_stb_o & ack_en[1] & (wcnt >= wait_st)) | spur1;
    assign bus.wb_ack_i = {w_ack1, w_ack0};
    assign bus.wb_dat_i = {mem1[w_idx], mem0[w_idx]};

    always @(posedge clk_sys_i) begin
        if (bus.wb_cyc_o != 2'b00 && bus.wb_ack_i == 2'b00) wcnt <= wcnt + 1;
        else                                                wcnt <= 0;
        if (w_ack0 && bus.wb_cyc_o[0] && bus.wb_we_o) mem0[w_idx] <= bus.wb_dat_o;
        if (w_ack1 && bus.wb_cyc_o[1] && bus.wb_we_o) mem1[w_idx] <= bus.wb_dat_o;
    end

    // Drives one request and observes the bus/response at negedges; lat counts negedges after accept.
    task automatic host_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic got, output logic [31:0] rdata, output logic err,
                               output int lat, output logic [1:0] cyc_seen,
                               output logic [31:0] adr_seen, output logic [31:0] dat_seen,
                               output int cyc_cnt, output logic rdy_ok);
        int n;
        got = 1'b0; rdata = '0; err = 1'b0; lat = 0; cyc_seen = '0;
        adr_seen = '0; dat_seen = '0; cyc_cnt = 0; rdy_ok = 1'b1;
        @(negedge clk_sys_i);
        n = 0;
        while (!bus.host_ready_o && n < 100) begin
            @(negedge clk_sys_i);
            n++;
        end
        bus.host_req_i   = 1'b1;
        bus.host_we_i    = we;
        bus.host_addr_i  = addr;
        bus.host_wdata_i = wdata;
        @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        bus.host_req_i = 1'b0;
        for (int c = 1; c <= BOUND && !got; c++) begin
            if (bus.wb_cyc_o != 2'b00) begin
                cyc_seen |= bus.wb_cyc_o;
                adr_seen = bus.wb_adr_o;
                dat_seen = bus.wb_dat_o;
                cyc_cnt++;
            end
            if (bus.host_ready_o) rdy_ok = 1'b0;
            if (bus.host_rsp_valid_o) begin
                got   = 1'b1;
                lat   = c;
                rdata = bus.host_rsp_data_o;
                err   = bus.host_rsp_err_o;
            end else begin
                @(negedge clk_sys_i);
            end
        end
        if (got) begin
            @(negedge clk_sys_i);
            if (!bus.host_ready_o || bus.host_rsp_valid_o) rdy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.host_ready_o !== 1'b1 || bus.host_rsp_valid_o !== 1'b0 || bus.host_rsp_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_host got rdy=%b vld=%b err=%b want 1 0 0",
                     bus.host_ready_o, bus.host_rsp_valid_o, bus.host_rsp_err_o);
        end
        tests_run++;
        if (bus.host_rsp_data_o !== 32'h0 || bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data got rsp=%h adr=%h dat=%h want all 0",
                     bus.host_rsp_data_o, bus.wb_adr_o, bus.wb_dat_o);
        end
        tests_run++;
        if (bus.wb_cyc_o !== 2'b00 || bus.wb_stb_o !== 1'b0 || bus.wb_we_o !== 1'b0 || bus.wb_sel_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_wb got cyc=%b stb=%b we=%b sel=%h want 0",
                     bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o);
        end
    endtask

    task automatic test_wrpc_window();
        row_t rows [6] = '{
            '{1'b1, 32'h0008_0100, 32'hDEAD_BEEF, 2'b01, 32'h0000_0100, 32'h0000_0000, 1'b0},
            '{1'b1, 32'h0008_0104, 32'hCAFE_BABE, 2'b01, 32'h0000_0104, 32'h0000_0000, 1'b0},
            '{1'b0, 32'h0008_0100, 32'h0000_0000, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0},
            '{1'b0, 32'h0008_0104, 32'h0000_0000, 2'b01, 32'h0000_0104, 32'hCAFE_BABE, 1'b0},
            '{1'b1, 32'h0009_FFFC, 32'h1234_5678, 2'b01, 32'h0001_FFFC, 32'h0000_0000, 1'b0},
            '{1'b0, 32'h0009_FFFC, 32'h0000_0000, 2'b01, 32'h0001_FFFC, 32'h1234_5678, 1'b0}};
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        foreach (rows[i]) begin
            sb_q.push_back('{rows[i].rdata, rows[i].err});
            host_access(rows[i].we, rows[i].addr, rows[i].wdata, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
            e = sb_q.pop_front();
            tests_run++;
            if (!got || rd !== e.data || er !== e.err) begin
                tests_failed++;
                $display("FAIL wrpc_rsp[%0d] got vld=%b data=%h err=%b want data=%h err=%b", i, got, rd, er, e.data, e.err);
            end
            tests_run++;
            if (cyc !== rows[i].cyc || adr !== rows[i].adr || (rows[i].we && dat !== rows[i].wdata)) begin
                tests_failed++;
                $display("FAIL wrpc_bus[%0d] got cyc=%b adr=%h dat=%h want cyc=%b adr=%h dat=%h",
                         i, cyc, adr, dat, rows[i].cyc, rows[i].adr, rows[i].wdata);
            end
        end
    endtask

    task automatic test_periph_window();
        row_t rows [5] = '{
            '{1'b1, 32'h000A_0400, 32'h1DEA_DBEE, 2'b10, 32'h0000_0400, 32'h0000_0000, 1'b0},
            '{1'b1, 32'h000A_0400, 32'h0DEA_DBEE, 2'b10, 32'h0000_0400, 32'h0000_0000, 1'b0},
            '{1'b1, 32'h000A_021C, 32'h0000_FAFA, 2'b10, 32'h0000_021C, 32'h0000_0000, 1'b0},
            '{1'b0, 32'h000A_0403, 32'h0000_0000, 2'b10, 32'h0000_0400, 32'h0DEA_DBEE, 1'b0},
            '{1'b0, 32'h000A_021C, 32'h0000_0000, 2'b10, 32'h0000_021C, 32'h0000_FAFA, 1'b0}};
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        foreach (rows[i]) begin
            sb_q.push_back('{rows[i].rdata, rows[i].err});
            host_access(rows[i].we, rows[i].addr, rows[i].wdata, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
            e = sb_q.pop_front();
            tests_run++;
            if (!got || rd !== e.data || er !== e.err) begin
                tests_failed++;
                $display("FAIL periph_rsp[%0d] got vld=%b data=%h err=%b want data=%h err=%b", i, got, rd, er, e.data, e.err);
            end
            tests_run++;
            if (cyc !== rows[i].cyc || adr !== rows[i].adr || (rows[i].we && dat !== rows[i].wdata)) begin
                tests_failed++;
                $display("FAIL periph_bus[%0d] got cyc=%b adr=%h dat=%h want cyc=%b adr=%h dat=%h",
                         i, cyc, adr, dat, rows[i].cyc, rows[i].adr, rows[i].wdata);
            end
        end
    endtask

    task automatic test_unmapped();
        row_t rows [3] = '{
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b1},
            '{1'b1, 32'h000C_0000, 32'h0000_0055, 2'b00, 32'h0, 32'h0000_0000, 1'b1},
            '{1'b0, 32'h0007_FFFC, 32'h0000_0000, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b1}};
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        foreach (rows[i]) begin
            sb_q.push_back('{rows[i].rdata, rows[i].err});
            host_access(rows[i].we, rows[i].addr, rows[i].wdata, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
            e = sb_q.pop_front();
            tests_run++;
            if (!got || rd !== e.data || er !== e.err) begin
                tests_failed++;
                $display("FAIL unmapped_rsp[%0d] got vld=%b data=%h err=%b want data=%h err=%b", i, got, rd, er, e.data, e.err);
            end
            tests_run++;
            if (cyc !== 2'b00 || lat != 2) begin
                tests_failed++;
                $display("FAIL unmapped_bus[%0d] got cyc=%b lat=%0d want cyc=00 lat=2", i, cyc, lat);
            end
        end
    endtask

    task automatic test_timeout();
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        ack_en = 2'b10;
        spur1  = 1'b1;
        sb_q.push_back('{32'hFFFF_FFFF, 1'b1});
        host_access(1'b0, 32'h0008_0100, 32'h0, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || rd !== e.data || er !== e.err) begin
            tests_failed++;
            $display("FAIL timeout_rd_rsp got vld=%b data=%h err=%b want data=%h err=%b", got, rd, er, e.data, e.err);
        end
        tests_run++;
        if (ncyc != TO || cyc !== 2'b01 || lat != TO + 1) begin
            tests_failed++;
            $display("FAIL timeout_len got cyc_cycles=%0d cyc=%b lat=%0d want %0d 01 %0d", ncyc, cyc, lat, TO, TO + 1);
        end
        sb_q.push_back('{32'h0, 1'b1});
        host_access(1'b1, 32'h0008_0100, 32'h1111_1111, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || rd !== e.data || er !== e.err) begin
            tests_failed++;
            $display("FAIL timeout_wr_rsp got vld=%b data=%h err=%b want data=%h err=%b", got, rd, er, e.data, e.err);
        end
        ack_en = 2'b11;
        spur1  = 1'b0;
        sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
        host_access(1'b0, 32'h0008_0100, 32'h0, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || rd !== e.data || er !== e.err) begin
            tests_failed++;
            $display("FAIL timeout_recover got vld=%b data=%h err=%b want data=%h err=%b", got, rd, er, e.data, e.err);
        end
    endtask

    task automatic test_zero_wait();
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        wait_st = 0;
        sb_q.push_back('{32'hCAFE_BABE, 1'b0});
        host_access(1'b0, 32'h0008_0104, 32'h0, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || rd !== e.data || er !== e.err) begin
            tests_failed++;
            $display("FAIL zw_rsp got vld=%b data=%h err=%b want data=%h err=%b", got, rd, er, e.data, e.err);
        end
        tests_run++;
        if (lat != 2 || !rok) begin
            tests_failed++;
            $display("FAIL zw_timing got lat=%0d ready_window_ok=%b want lat=2 ok=1", lat, rok);
        end
        repeat (3) @(negedge clk_sys_i);
        tests_run++;
        if (bus.host_rsp_data_o !== 32'hCAFE_BABE || bus.host_rsp_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsp_hold got data=%h err=%b want cafebabe 0", bus.host_rsp_data_o, bus.host_rsp_err_o);
        end
    endtask

    task automatic test_wait_states();
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        wait_st = 3;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back('{(k == 0) ? 32'h0 : 32'h0000_5A5A, 1'b0});
            host_access(k == 0, 32'h000A_0404, 32'h0000_5A5A, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
            e = sb_q.pop_front();
            tests_run++;
            if (!got || rd !== e.data || er !== e.err || lat != 5 || !rok) begin
                tests_failed++;
                $display("FAIL wait_states[%0d] got data=%h err=%b lat=%0d rok=%b want data=%h err=%b lat=5 rok=1",
                         k, rd, er, lat, rok, e.data, e.err);
            end
        end
        wait_st = 0;
    endtask

    task automatic test_reset_mid_bus();
        int n_rsp = 0;
        logic got, er, rok; logic [31:0] rd, adr, dat; logic [1:0] cyc; int lat, ncyc; exp_t e;
        ack_en = 2'b00;
        @(negedge clk_sys_i);
        bus.host_req_i  = 1'b1;
        bus.host_we_i   = 1'b0;
        bus.host_addr_i = 32'h0008_0100;
        @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        bus.host_req_i = 1'b0;
        tests_run++;
        if (bus.wb_cyc_o !== 2'b01 || bus.wb_stb_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre got cyc=%b stb=%b want 01 1", bus.wb_cyc_o, bus.wb_stb_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        tests_run++;
        if (bus.wb_cyc_o !== 2'b00 || bus.wb_stb_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async got cyc=%b stb=%b want 00 0", bus.wb_cyc_o, bus.wb_stb_o);
        end
        repeat (3) begin
            @(negedge clk_sys_i);
            if (bus.host_rsp_valid_o) n_rsp++;
        end
        rst_n_i = 1'b1;
        ack_en  = 2'b11;
        repeat (2) begin
            @(negedge clk_sys_i);
            if (bus.host_rsp_valid_o) n_rsp++;
        end
        tests_run++;
        if (n_rsp != 0 || bus.host_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_release got rsp_pulses=%0d ready=%b want 0 1", n_rsp, bus.host_ready_o);
        end
        sb_q.push_back('{32'hCAFE_BABE, 1'b0});
        host_access(1'b0, 32'h0008_0104, 32'h0, got, rd, er, lat, cyc, adr, dat, ncyc, rok);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || rd !== e.data || er !== e.err) begin
            tests_failed++;
            $display("FAIL rst_recover got vld=%b data=%h err=%b want data=%h err=%b", got, rd, er, e.data, e.err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        bus.host_req_i   = 1'b0;
        bus.host_we_i    = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_sys_i);
        test_reset();
        rst_n_i = 1'b1;
        @(negedge clk_sys_i);
        test_wrpc_window();
        test_periph_window();
        test_unmapped();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_reset_mid_bus();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
